// File: rtl/inst_sequencer.sv
// Instruction sequencer: buffers a short program and issues it to the PE array, then drains.
// Define SEQ_LOOP_EN to run loop_cnt back-to-back passes; otherwise exactly one pass runs.
module inst_sequencer #(
   parameter int INST_WIDTH = 64,
   parameter int IMEM_DEPTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int DRAIN      = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [INST_WIDTH-1:0] wr_inst,
   input  logic [ADDR_WIDTH:0]   prog_len,
   input  logic [7:0]            loop_cnt,
   input  logic                  start,
   input  logic                  stall,
   output logic                  inst_v,
   output logic [INST_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy,
   output logic                  done
);

   localparam int LW = ADDR_WIDTH + 1;
   localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [LW-1:0] DEPTH_L    = LW'(IMEM_DEPTH);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [LW-1:0]         len_q, len_d;
   logic [INST_WIDTH-1:0] inst_q, inst_d;
   logic                  inst_v_q, inst_v_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [DW-1:0]         drain_q, drain_d;

   logic [INST_WIDTH-1:0] imem_q [IMEM_DEPTH];

   logic start_run;
   logic last_entry;
   logic pass_end;
   logic final_pass;

   assign start_run  = (state_q == S_IDLE) && start && (prog_len != '0);
   assign last_entry = ({1'b0, pc_q} == (len_q - LW'(1)));
   assign pass_end   = (state_q == S_RUN) && !stall && last_entry;

   // Buffer survives reset on purpose so a program can be rerun after an abort.
   always_ff @(posedge clk) begin
      if ((state_q == S_IDLE) && wr_en) begin
         imem_q[wr_addr] <= wr_inst;
      end
   end

`ifdef SEQ_LOOP_EN
   logic [7:0] loop_q, loop_d;
   logic [7:0] pass_q, pass_d;

   assign final_pass = (pass_q == (loop_q - 8'd1));

   always_comb begin
      loop_d = loop_q;
      pass_d = pass_q;
      if (start_run) begin
         loop_d = (loop_cnt == '0) ? 8'd1 : loop_cnt;
         pass_d = '0;
      end else if (pass_end) begin
         pass_d = final_pass ? '0 : pass_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loop_q <= '0;
         pass_q <= '0;
      end else begin
         loop_q <= loop_d;
         pass_q <= pass_d;
      end
   end
`else
   logic loop_cnt_unused;
   logic start_run_unused;
   logic pass_end_unused;

   assign final_pass       = 1'b1;
   assign loop_cnt_unused  = ^loop_cnt;
   assign start_run_unused = start_run;
   assign pass_end_unused  = pass_end;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      len_d    = len_q;
      inst_d   = inst_q;
      inst_v_d = 1'b0;
      done_d   = 1'b0;
      drain_d  = drain_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (prog_len == '0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
                  pc_d    = '0;
                  len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
               end
            end
         end
         S_RUN: begin
            if (!stall) begin
               inst_d   = imem_q[pc_q];
               inst_v_d = 1'b1;
               if (last_entry) begin
                  pc_d = '0;
                  if (final_pass) begin
                     state_d = S_DRAIN;
                     drain_d = '0;
                  end
               end else begin
                  pc_d = pc_q + ADDR_WIDTH'(1);
               end
            end
         end
         S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               drain_d = '0;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         len_q    <= '0;
         inst_q   <= '0;
         inst_v_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         len_q    <= len_d;
         inst_q   <= inst_d;
         inst_v_q <= inst_v_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         drain_q  <= drain_d;
      end
   end

   assign inst_v = inst_v_q;
   assign inst   = inst_q;
   assign pc     = pc_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: doc/inst_sequencer.md
INST_SEQUENCER -- requirements
Module: inst_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: INST_WIDTH, 64, instruction width; IMEM_DEPTH, 16, instruction buffer entries; ADDR_WIDTH, 4, log2(IMEM_DEPTH); DRAIN, 6, cycles waited after the last issue for the PE pipeline to empty.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- wr_en  in  1  instruction buffer write strobe.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_inst  in  INST_WIDTH  instruction to store.
- prog_len  in  ADDR_WIDTH+1  instructions per pass, 0..IMEM_DEPTH.
- loop_cnt  in  8  number of passes.
- start  in  1  single-cycle run request.
- stall  in  1  holds issue while high.
- inst_v  out  1  issued-instruction valid, drives the PE control inst_v.
- inst  out  INST_WIDTH  issued instruction.
- pc  out  ADDR_WIDTH  address of the next instruction to issue.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states SHALL be IDLE, RUN, DRAIN and DONE; all outputs SHALL be registered.
REQ-004 IDLE: wr_en=1 SHALL write wr_inst to imem[wr_addr] at the clock edge; wr_en SHALL be ignored in every other state.
REQ-005 IDLE with start=1 and prog_len>0 SHALL latch prog_len and loop_cnt, clear pc, and enter RUN at the same edge.
REQ-006 A prog_len value greater than IMEM_DEPTH SHALL be clamped to IMEM_DEPTH when latched.
REQ-007 IDLE with start=1 and prog_len=0 SHALL go directly to DONE with no issue.
REQ-008 start SHALL be ignored while busy=1.
REQ-009 The instruction buffer SHALL have an asynchronous read, so the instruction at pc is available in the same cycle.
REQ-010 RUN with stall=0 SHALL issue on each edge: inst<=imem[pc], inst_v<=1, pc<=pc+1. The first inst_v SHALL be high in the cycle after the edge that enters RUN.
REQ-011 RUN with stall=1 SHALL set inst_v<=0 and hold pc and inst; no instruction SHALL be skipped or duplicated.
REQ-012 Issuing the entry at pc=prog_len-1 SHALL end the pass: pc SHALL wrap to 0, and the pass counter SHALL then decide the next state (REQ-021).
REQ-013 DRAIN SHALL force inst_v=0, hold inst, and count DRAIN cycles, then enter DONE.
REQ-014 stall SHALL have no effect in DRAIN.
REQ-015 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-016 pc SHALL wrap modulo prog_len and SHALL never address an entry at or beyond prog_len.
REQ-017 busy SHALL be 1 in RUN, DRAIN and DONE.
REQ-018 A write and a start in the same IDLE cycle SHALL both take effect; the written entry SHALL be visible to the first issue.

Reset
REQ-019 rst=1 SHALL immediately force IDLE with inst_v=0, inst=0, pc=0, busy=0 and done=0, including when it arrives mid-RUN or mid-DRAIN; the pass and drain counters SHALL also clear to 0.
REQ-020 Instruction buffer contents SHALL NOT be cleared by rst.

Configuration
REQ-021 When the macro SEQ_LOOP_EN is defined, the sequencer SHALL run loop_cnt passes back-to-back with no bubble between passes (loop_cnt=0 treated as 1), and SHALL enter DRAIN only after the final pass; when SEQ_LOOP_EN is undefined, loop_cnt SHALL be ignored, exactly one pass SHALL run, and the pass counter SHALL not be built.

Verification
REQ-022 Load 3 instructions (A, B, C), prog_len=3, start, no stall -> inst_v high 3 consecutive cycles carrying A, B, C; done 1 cycle high, 6 cycles after C; busy low the cycle after done.
REQ-023 Same program, stall=1 for 2 cycles after A is issued -> sequence A, gap, gap, B, C; no repeat or skip; pc holds at 1 during the stall.
REQ-024 With SEQ_LOOP_EN defined: prog_len=2 (A, B), loop_cnt=3 -> A,B,A,B,A,B on 6 consecutive valid cycles, then a single done pulse; with SEQ_LOOP_EN undefined -> A,B only.
REQ-025 start with prog_len=0 -> no inst_v; done high in the cycle after start.
REQ-026 rst asserted mid-RUN after 1 of 4 issues -> inst_v=0 and busy=0 immediately; a new start reissues from entry 0 using the unchanged buffer contents.
REQ-027 wr_en and start asserted during RUN -> buffer unchanged, run unaffected; write and start in the same IDLE cycle to entry 0 -> the new value is issued first.
